// File: rtl/chacha_block_core.sv
`default_nettype none
// ============================================================================
// chacha_block_core : word-serial ChaCha block function, one quarter-round
//                     per cycle, feed-forward added on the output stream.
// Revision: 1.0
// ============================================================================

module chacha_qr (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out
);
    logic [31:0] w_a1, w_d1x, w_d1, w_c1, w_b1x, w_b1;
    logic [31:0] w_a2, w_d2x, w_d2, w_c2, w_b2x, w_b2;

    assign w_a1  = a + b;
    assign w_d1x = d ^ w_a1;
    assign w_d1  = {w_d1x[15:0], w_d1x[31:16]};
    assign w_c1  = c + w_d1;
    assign w_b1x = b ^ w_c1;
    assign w_b1  = {w_b1x[19:0], w_b1x[31:20]};
    assign w_a2  = w_a1 + w_b1;
    assign w_d2x = w_d1 ^ w_a2;
    assign w_d2  = {w_d2x[23:0], w_d2x[31:24]};
    assign w_c2  = w_c1 + w_d2;
    assign w_b2x = w_b1 ^ w_c2;
    assign w_b2  = {w_b2x[24:0], w_b2x[31:25]};

    assign a_out = w_a2;
    assign b_out = w_b2;
    assign c_out = w_c2;
    assign d_out = w_d2;
endmodule

module chacha_block_core #(
    parameter int DOUBLE_ROUNDS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);
    localparam int STEP_W = $clog2(8 * DOUBLE_ROUNDS);
    localparam logic [STEP_W-1:0] C_LAST_STEP = STEP_W'(8 * DOUBLE_ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ROUND = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t            r_state, w_next_state;
    logic [31:0]       r_orig [16];
    logic [31:0]       r_work [16];
    logic [3:0]        r_idx;
    logic [STEP_W-1:0] r_step;
    logic              w_load, w_round, w_out;

    // Quarter-round operand selection: a is always the low column index; the
    // diagonal steps rotate b, c and d by 1, 2 and 3 lanes respectively.
    logic [1:0]  w_j;
    logic        w_diag;
    logic [1:0]  w_jb, w_jc, w_jd;
    logic [3:0]  w_ia, w_ib, w_ic, w_id;
    logic [31:0] w_qa, w_qb, w_qc, w_qd;

    assign w_j    = r_step[1:0];
    assign w_diag = r_step[2];
    assign w_jb   = w_j + {1'b0, w_diag};
    assign w_jc   = w_j + {w_diag, 1'b0};
    assign w_jd   = w_j + {w_diag, w_diag};
    assign w_ia   = {2'b00, w_j};
    assign w_ib   = {2'b01, w_jb};
    assign w_ic   = {2'b10, w_jc};
    assign w_id   = {2'b11, w_jd};

    chacha_qr u_qr (
        .a     (r_work[w_ia]),
        .b     (r_work[w_ib]),
        .c     (r_work[w_ic]),
        .d     (r_work[w_id]),
        .a_out (w_qa),
        .b_out (w_qb),
        .c_out (w_qc),
        .d_out (w_qd)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_LOAD;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_round      = 1'b0;
        w_out        = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_load = 1'b1;
                if (in_valid && r_idx == 4'd15) w_next_state = ST_ROUND;
            end
            ST_ROUND: begin
                w_round = 1'b1;
                if (r_step == C_LAST_STEP) w_next_state = ST_OUT;
            end
            ST_OUT: begin
                w_out = 1'b1;
                if (out_ready && r_idx == 4'd15) w_next_state = ST_LOAD;
            end
            default: w_next_state = ST_LOAD;
        endcase
    end

    // Held-reset must not advertise readiness even though the state is LOAD.
    assign in_ready  = w_load & ~rst;
    assign busy      = w_round;
    assign out_valid = w_out;
    assign out_data  = w_out ? (r_work[r_idx] + r_orig[r_idx]) : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= 4'd0;
            r_step <= '0;
        end else begin
            if (w_load && in_valid) begin
                r_orig[r_idx] <= in_data;
                r_work[r_idx] <= in_data;
                r_idx         <= r_idx + 4'd1;
                r_step        <= '0;
            end
            if (w_round) begin
                r_work[w_ia] <= w_qa;
                r_work[w_ib] <= w_qb;
                r_work[w_ic] <= w_qc;
                r_work[w_id] <= w_qd;
                r_idx        <= 4'd0;
                r_step       <= (r_step == C_LAST_STEP) ? '0 : r_step + 1'b1;
            end
            if (w_out && out_ready) r_idx <= r_idx + 4'd1;
        end
    end
endmodule
`default_nettype wire

// File: doc/chacha_block_core.md
Name: chacha_block_core

Overview:
- Sequential ChaCha20 block function built around one instance of the existing `chacha_qr` quarter-round.
- Accepts a 16-word input state over a word-serial valid/ready stream and runs the double rounds, one quarter-round per cycle.
- Performs the feed-forward addition and streams the 16 keystream words out over a second valid/ready stream.
- Sits between the state-assembly logic (key/counter/nonce packer) upstream and the keystream XOR/output serializer downstream.

Parameters:
- DOUBLE_ROUNDS, 10, number of column+diagonal double rounds; must be ≥1. Default 10 gives ChaCha20.

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous reset, active-high
- in_data  input  32  input state word; word 0 first, word 15 last
- in_valid  input  1  in_data valid
- in_ready  output  1  core accepts a word this cycle
- out_data  output  32  keystream word (working[i]+orig[i] mod 2^32); word 0 first
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- busy  output  1  high in ROUND state

Behaviour:
- Reset values: in_ready=0, out_valid=0, busy=0, out_data=0, word index=0, step=0, state=LOAD.
  - in_ready rises the first cycle after rst deasserts.
  - rst mid-operation aborts any block; no partial output.
- Storage: orig[0..15] and work[0..15], 32 bits each.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid&in_ready writes in_data to orig[idx] and work[idx], then idx++.
  - On the 16th transfer (idx=15): idx←0, step←0, go to ROUND.
  - in_valid with in_ready=0 is ignored; data must be held by upstream.
- ROUND:
  - in_ready=0, busy=1.
  - step runs 0..8*DOUBLE_ROUNDS-1; q=step mod 8. Each cycle feeds (a,b,c,d) = work at the indices below into `chacha_qr` and writes the four results back to the same indices.
  - Column steps: q0 (0,4,8,12), q1 (1,5,9,13), q2 (2,6,10,14), q3 (3,7,11,15).
  - Diagonal steps: q4 (0,5,10,15), q5 (1,6,11,12), q6 (2,7,8,13), q7 (3,4,9,14).
  - After the final step, go to OUT with idx=0.
  - Round phase lasts exactly 80 cycles for the default parameter.
- OUT:
  - out_valid=1; out_data=work[idx]+orig[idx] (32-bit wrap).
  - out_data is stable while out_valid&!out_ready.
  - On out_valid&out_ready: idx++. On the 16th transfer, go to LOAD with idx=0.
    - out_valid drops the next cycle and in_ready rises the same next cycle.
  - out_ready may be held low indefinitely; no data loss, no timeout.
- Timing with no stalls:
  - Last input transfer at cycle T → first round at T+1 → out_valid first high at T+81 (default).
  - 16-word block throughput = 16+80+16 = 112 cycles.
- in_ready and out_valid are never both high. Only one block is in flight.
- All additions are mod 2^32; no carry is retained.

Test Plan:
- RFC 8439 §2.3.2: load 61707865 3320646e 79622d32 6b206574 03020100 07060504 0b0a0908 0f0e0d0c 13121110 17161514 1b1a1918 1f1e1d1c 00000001 09000000 4a000000 00000000, out_ready=1 -> out words e4e7f110 15593bd1 1fdd0f50 c47120a3 c7f4d1c7 0368c033 9aaa2204 4e6cd4c3 466482d2 09aa9f07 05d7c214 a2028bd9 d19c12b5 b94e16de e883d0cb 4e3c50a2; out_valid first high exactly 81 cycles after the last input transfer.
- All-zero key/nonce/counter: load constants 61707865 3320646e 79622d32 6b206574 then twelve 00000000 -> first four out words ade0b876 903df1a0 e56a5d40 28bd8653.
- Backpressure:
  - Upstream: random in_valid gaps during LOAD.
  - Downstream: out_ready low 5 cycles on word 0 and random thereafter.
  - Required: identical output sequence to the §2.3.2 case; out_data held constant while stalled.
- Handshake exclusivity: in_valid held high during ROUND/OUT -> in_ready=0, no orig/work change, busy=1 only during the 80 round cycles.
- Reset mid-operation:
  - rst asserted for 1 cycle at step 37 -> next cycle out_valid=0, busy=0; in_ready=1 the cycle after rst drops.
  - A fresh §2.3.2 load then produces the correct vector.
- Back-to-back blocks: two loads with counter 1 then 2, out_ready=1 -> second block's in_ready rises the cycle after the 16th output transfer; both outputs match software model.
